midi_stream_parser: RTL



---
 rtl/midi_stream_parser_if.sv | 22 ++
 rtl/midi_stream_parser.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/midi_stream_parser_if.sv
// Byte-in / event-out bundle between the MIDI byte source, the parser and the
// synth voice/channel logic.
interface midi_stream_parser_if;
  logic        byte_valid;
  logic [7:0]  data;
  logic        ev_valid;
  logic [2:0]  ev_type;
  logic [3:0]  ev_channel;
  logic [6:0]  ev_data1;
  logic [6:0]  ev_data2;
  logic [13:0] ev_bend;

  modport master (
    output byte_valid, data,
    input  ev_valid, ev_type, ev_channel, ev_data1, ev_data2, ev_bend
  );

  modport slave (
    input  byte_valid, data,
    output ev_valid, ev_type, ev_channel, ev_data1, ev_data2, ev_bend
  );
endinterface

// File: rtl/midi_stream_parser.sv
// MIDI byte-stream parser with running status, realtime pass-through, SysEx
// skipping and per-channel held-note tracking.
//
// state   | meaning
// IDLE    | no running status; data bytes are orphans
// WAIT_D1 | running status valid, expecting first data byte
// WAIT_D2 | first data byte held, expecting second
// SYSEX   | inside a system-exclusive dump; data bytes dropped
module midi_stream_parser #(
  parameter int NUM_CHANNELS = 16,
  parameter int CNT_W        = 4,
  parameter int ALL_OFF_CC   = 123
) (
  input  logic                    EXT_CLK,
  input  logic                    RST,
  midi_stream_parser_if.slave     bus,
  output logic [NUM_CHANNELS-1:0] chan_active,
  output logic                    rt_clock,
  output logic [7:0]              err_count
);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [6:0]       ALL_OFF = 7'(ALL_OFF_CC);

  state_t           state;
  logic [2:0]       run_cmd;
  logic [3:0]       run_chan;
  logic [6:0]       d1_q;
  logic [CNT_W-1:0] cnt_q    [NUM_CHANNELS];
  logic [CNT_W-1:0] cnt_next [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] active_next;

  logic       is_data, is_chan_status, is_sysex_start, is_common;
  logic       is_rt_clock, is_sys_reset;
  logic       single_data, msg_done, chan_ok, ev_fire;
  logic [6:0] msg_d1, msg_d2;
  logic [2:0] msg_type;

  always_comb begin
    is_data        = bus.byte_valid && !bus.data[7];
    is_chan_status = bus.byte_valid && bus.data[7] && (bus.data[7:4] != 4'hF);
    is_sysex_start = bus.byte_valid && (bus.data == 8'hF0);
    is_common      = bus.byte_valid && (bus.data >= 8'hF1) && (bus.data <= 8'hF7);
    is_rt_clock    = bus.byte_valid && (bus.data == 8'hF8);
    is_sys_reset   = bus.byte_valid && (bus.data == 8'hFF);

    // Program change (Cx) and channel pressure (Dx) carry one data byte.
    single_data = (run_cmd == 3'd4) || (run_cmd == 3'd5);
    msg_done    = is_data && (((state == WAIT_D1) && single_data) || (state == WAIT_D2));
    chan_ok     = int'(run_chan) < NUM_CHANNELS;
    ev_fire     = msg_done && chan_ok;

    if (state == WAIT_D2) begin
      msg_d1 = d1_q;
      msg_d2 = bus.data[6:0];
    end else begin
      msg_d1 = bus.data[6:0];
      msg_d2 = '0;
    end
    msg_type = ((run_cmd == 3'd1) && (msg_d2 == 7'd0)) ? 3'd0 : run_cmd;
  end

  always_comb begin
    active_next = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      cnt_next[c] = cnt_q[c];
      if (is_sys_reset) begin
        cnt_next[c] = '0;
      end else if (ev_fire && (run_chan == 4'(c))) begin
        case (msg_type)
          3'd1: if (cnt_q[c] != CNT_MAX) cnt_next[c] = cnt_q[c] + 1'b1;
          3'd0: if (cnt_q[c] != '0) cnt_next[c] = cnt_q[c] - 1'b1;
          3'd3: if (msg_d1 == ALL_OFF) cnt_next[c] = '0;
          default: ;
        endcase
      end
      active_next[c] = (cnt_next[c] != '0);
    end
  end

  always_ff @(posedge EXT_CLK) begin
    if (RST) begin
      state          <= IDLE;
      run_cmd        <= '0;
      run_chan       <= '0;
      d1_q           <= '0;
      bus.ev_valid   <= 1'b0;
      bus.ev_type    <= '0;
      bus.ev_channel <= '0;
      bus.ev_data1   <= '0;
      bus.ev_data2   <= '0;
      bus.ev_bend    <= '0;
      rt_clock       <= 1'b0;
      err_count      <= '0;
      chan_active    <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= '0;
    end else begin
      bus.ev_valid <= 1'b0;
      rt_clock     <= is_rt_clock;
      chan_active  <= active_next;
      for (int c = 0; c < NUM_CHANNELS; c++) cnt_q[c] <= cnt_next[c];

      if (is_sys_reset) begin
        state          <= IDLE;
        run_cmd        <= '0;
        run_chan       <= '0;
        bus.ev_valid   <= 1'b1;
        bus.ev_type    <= 3'd7;
        bus.ev_channel <= '0;
        bus.ev_data1   <= '0;
        bus.ev_data2   <= '0;
        bus.ev_bend    <= '0;
      end else if (is_chan_status) begin
        state    <= WAIT_D1;
        run_cmd  <= bus.data[6:4];
        run_chan <= bus.data[3:0];
      end else if (is_sysex_start) begin
        state    <= SYSEX;
        run_cmd  <= '0;
        run_chan <= '0;
      end else if (is_common) begin
        state    <= IDLE;
        run_cmd  <= '0;
        run_chan <= '0;
      end else if (is_data) begin
        case (state)
          IDLE: if (err_count != 8'hFF) err_count <= err_count + 1'b1;
          WAIT_D1: begin
            d1_q <= bus.data[6:0];
            if (!single_data) state <= WAIT_D2;
          end
          WAIT_D2: state <= WAIT_D1;
          default: ;
        endcase
        if (ev_fire) begin
          bus.ev_valid   <= 1'b1;
          bus.ev_type    <= msg_type;
          bus.ev_channel <= run_chan;
          bus.ev_data1   <= msg_d1;
          bus.ev_data2   <= msg_d2;
          bus.ev_bend    <= (run_cmd == 3'd6) ? {msg_d2, msg_d1} : 14'd0;
        end
      end
    end
  end

endmodule
